// File: rtl/register_renamer_if.sv
// rtl/register_renamer_if.sv - decoder/ROB-facing signal bundle of the rename stage
// master drives decode, retire and rollback traffic; slave is the renamer.
interface register_renamer_if #(
  parameter int REG_FILE_ADDR_WIDTH = 7
);
  logic                           rename_valid;
  logic                           rename_ready;
  logic [31:0]                    rename_instr;
  logic                           rename_has_dest;
  logic [REG_FILE_ADDR_WIDTH-1:0] src1_phys;
  logic [REG_FILE_ADDR_WIDTH-1:0] src2_phys;
  logic                           rob_full;
  logic                           rob_write_en;
  logic [31:0]                    rob_instr;
  logic [REG_FILE_ADDR_WIDTH-1:0] rob_dest_reg;
  logic [REG_FILE_ADDR_WIDTH-1:0] rob_old_dest_reg;
  logic                           retire_valid;
  logic [REG_FILE_ADDR_WIDTH-1:0] retire_old_dest_reg;
  logic                           rollback_valid;
  logic [31:0]                    rollback_instr;
  logic [REG_FILE_ADDR_WIDTH-1:0] rollback_dest_reg;
  logic [REG_FILE_ADDR_WIDTH-1:0] rollback_old_dest_reg;
  logic [REG_FILE_ADDR_WIDTH:0]   free_count;
  logic                           rolling_back;

  modport master (
    output rename_valid, rename_instr, rename_has_dest, rob_full,
           retire_valid, retire_old_dest_reg,
           rollback_valid, rollback_instr, rollback_dest_reg, rollback_old_dest_reg,
    input  rename_ready, src1_phys, src2_phys, rob_write_en, rob_instr,
           rob_dest_reg, rob_old_dest_reg, free_count, rolling_back
  );

  modport slave (
    input  rename_valid, rename_instr, rename_has_dest, rob_full,
           retire_valid, retire_old_dest_reg,
           rollback_valid, rollback_instr, rollback_dest_reg, rollback_old_dest_reg,
    output rename_ready, src1_phys, src2_phys, rob_write_en, rob_instr,
           rob_dest_reg, rob_old_dest_reg, free_count, rolling_back
  );
endinterface

// File: rtl/register_renamer.sv
// rtl/register_renamer.sv - rename stage: alias table, circular free list, rollback FSM
// Allocates destination registers into the ROB, recycles on retire, restores on rollback.
module register_renamer #(
  parameter int REG_FILE_ADDR_WIDTH = 7,
  parameter int ARCH_REG_COUNT      = 32
) (
  input logic               i_clock,
  input logic               i_reset,
  register_renamer_if.slave rr_bus
);
  localparam int AW         = REG_FILE_ADDR_WIDTH;
  localparam int PHYS_COUNT = 1 << AW;
  localparam int INIT_FREE  = PHYS_COUNT - ARCH_REG_COUNT;

  typedef enum logic {ST_NORMAL, ST_ROLLBACK} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [AW-1:0] r_rat [ARCH_REG_COUNT];
  logic [AW-1:0] r_fl  [PHYS_COUNT];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;

  logic [4:0]    w_rd;
  logic [4:0]    w_rs1;
  logic [4:0]    w_rs2;
  logic [4:0]    w_rb_rd;
  logic          w_needs_alloc;
  logic          w_ready;
  logic          w_accept;
  logic          w_alloc;
  logic          w_rb_push;
  logic          w_ret_push;
  logic [AW:0]   w_count_next;

  assign w_rd    = rr_bus.rename_instr[11:7];
  assign w_rs1   = rr_bus.rename_instr[19:15];
  assign w_rs2   = rr_bus.rename_instr[24:20];
  assign w_rb_rd = rr_bus.rollback_instr[11:7];

  assign w_needs_alloc = rr_bus.rename_has_dest && (w_rd != 5'd0);
  assign w_ready       = i_reset && (r_state == ST_NORMAL) && !rr_bus.rollback_valid
                         && !rr_bus.rob_full && ((r_count != '0) || !w_needs_alloc);
  assign w_accept      = rr_bus.rename_valid && w_ready;
  assign w_alloc       = w_accept && w_needs_alloc;
  assign w_rb_push     = rr_bus.rollback_valid && (rr_bus.rollback_dest_reg != '0);
  assign w_ret_push    = rr_bus.retire_valid && (rr_bus.retire_old_dest_reg != '0);
  assign w_count_next  = r_count - {{AW{1'b0}}, w_alloc}
                         + {{AW{1'b0}}, w_rb_push} + {{AW{1'b0}}, w_ret_push};

  // Sources read the pre-update table, so rd==rs sees the previous mapping.
  assign rr_bus.rename_ready     = w_ready;
  assign rr_bus.rob_write_en     = w_accept;
  assign rr_bus.rob_instr        = rr_bus.rename_instr;
  assign rr_bus.src1_phys        = r_rat[w_rs1];
  assign rr_bus.src2_phys        = r_rat[w_rs2];
  assign rr_bus.rob_dest_reg     = w_needs_alloc ? r_fl[r_head] : '0;
  assign rr_bus.rob_old_dest_reg = w_needs_alloc ? r_rat[w_rd] : '0;
  assign rr_bus.free_count       = r_count;
  assign rr_bus.rolling_back     = i_reset && (r_state == ST_ROLLBACK);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_NORMAL:   if (rr_bus.rollback_valid) w_state_next = ST_ROLLBACK;
      ST_ROLLBACK: if (!rr_bus.rollback_valid) w_state_next = ST_NORMAL;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state <= ST_NORMAL;
      for (int i = 0; i < ARCH_REG_COUNT; i++) r_rat[i] <= AW'(i);
      for (int i = 0; i < PHYS_COUNT; i++) r_fl[i] <= (i < INIT_FREE) ? AW'(i + ARCH_REG_COUNT) : '0;
      r_head  <= '0;
      r_tail  <= AW'(INIT_FREE);
      r_count <= (AW+1)'(INIT_FREE);
    end else begin
      r_state <= w_state_next;
      if (w_alloc) begin
        r_rat[w_rd] <= r_fl[r_head];
        r_head      <= r_head + 1'b1;
      end
      // Rollback entry takes the first tail slot; a same-cycle retire lands behind it.
      if (w_rb_push) begin
        if (w_rb_rd != 5'd0) r_rat[w_rb_rd] <= rr_bus.rollback_old_dest_reg;
        r_fl[r_tail] <= rr_bus.rollback_dest_reg;
      end
      if (w_ret_push) r_fl[w_rb_push ? r_tail + 1'b1 : r_tail] <= rr_bus.retire_old_dest_reg;
      r_tail  <= r_tail + AW'(w_rb_push) + AW'(w_ret_push);
      r_count <= w_count_next;
    end
  end

  a_free_list_overflow: assert property (@(posedge i_clock) disable iff (!i_reset)
    w_count_next <= (AW+1)'(PHYS_COUNT));
endmodule

// File: tb/tb_register_renamer.sv
// tb/tb_register_renamer.sv - self-checking bench for register_renamer
// Directed scenarios plus randomized traffic against a queue-based alias/free-list/ROB model.
module tb_register_renamer;
  localparam int AW = 7;

  typedef struct {
    logic [31:0] instr;
    int          dest;
    int          old;
  } rob_e_t;

  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  int     n_vec = 0;
  int     n_err = 0;
  int     m_rat [32];
  int     m_fl  [$];
  bit     m_rb;
  rob_e_t rob_q [$];

  always #5 clk = ~clk;

  register_renamer_if #(.REG_FILE_ADDR_WIDTH(AW)) bus ();

  register_renamer #(.REG_FILE_ADDR_WIDTH(AW), .ARCH_REG_COUNT(32)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .rr_bus  (bus)
  );

  function automatic logic [31:0] mk(int rd, int rs1, int rs2);
    logic [31:0] v;
    v = 32'h0000_0013;
    v[11:7]  = rd[4:0];
    v[19:15] = rs1[4:0];
    v[24:20] = rs2[4:0];
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_rat[i] = i;
    m_fl.delete();
    for (int p = 32; p < 128; p++) m_fl.push_back(p);
    m_rb = 0;
  endfunction

  function automatic bit m_need();
    return bus.rename_has_dest && (bus.rename_instr[11:7] != 5'd0);
  endfunction

  function automatic bit m_ready();
    return !m_rb && !bus.rollback_valid && !bus.rob_full && (m_fl.size() != 0 || !m_need());
  endfunction

  // Applies this cycle's bench inputs to the model as they take effect at the next edge.
  function automatic void model_tick();
    int rd;
    rd = int'(bus.rename_instr[11:7]);
    if (bus.rename_valid && m_ready() && m_need()) m_rat[rd] = m_fl.pop_front();
    if (bus.rollback_valid && bus.rollback_dest_reg != 0) begin
      if (bus.rollback_instr[11:7] != 0) m_rat[bus.rollback_instr[11:7]] = int'(bus.rollback_old_dest_reg);
      m_fl.push_back(int'(bus.rollback_dest_reg));
    end
    if (bus.retire_valid && bus.retire_old_dest_reg != 0) m_fl.push_back(int'(bus.retire_old_dest_reg));
    m_rb = bus.rollback_valid;
  endfunction

  task automatic idle();
    bus.rename_valid = 0; bus.rename_instr = '0; bus.rename_has_dest = 0; bus.rob_full = 0;
    bus.retire_valid = 0; bus.retire_old_dest_reg = '0;
    bus.rollback_valid = 0; bus.rollback_instr = '0;
    bus.rollback_dest_reg = '0; bus.rollback_old_dest_reg = '0;
  endtask

  task automatic tick();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle();
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    bus.rename_valid = 1; bus.rename_has_dest = 1; bus.rename_instr = mk(5, 0, 0);
    bus.rollback_valid = 1;
    @(posedge clk);
    #2;
    n_vec++; if (bus.rename_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %0b want 0", bus.rename_ready); end
    n_vec++; if (bus.rob_write_en !== 1'b0) begin n_err++; $display("FAIL reset_wen got %0b want 0", bus.rob_write_en); end
    n_vec++; if (bus.rolling_back !== 1'b0) begin n_err++; $display("FAIL reset_rb got %0b want 0", bus.rolling_back); end
    bus.rollback_valid = 0;
    rst_n = 1;
    model_reset();
    #1;
    n_vec++; if (bus.free_count !== 8'd96) begin n_err++; $display("FAIL reset_count got %0d want 96", bus.free_count); end
    n_vec++; if (bus.rename_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_after got %0b want 1", bus.rename_ready); end
    idle();
  endtask

  task automatic test_first_rename();
    apply_reset();
    bus.rename_valid = 1; bus.rename_has_dest = 1; bus.rename_instr = mk(5, 0, 0);
    #2;
    n_vec++; if (bus.rob_write_en !== 1'b1) begin n_err++; $display("FAIL t1_wen got %0b want 1", bus.rob_write_en); end
    n_vec++; if (bus.rob_dest_reg !== AW'(32)) begin n_err++; $display("FAIL t1_dest got %0d want 32", bus.rob_dest_reg); end
    n_vec++; if (bus.rob_old_dest_reg !== AW'(5)) begin n_err++; $display("FAIL t1_old got %0d want 5", bus.rob_old_dest_reg); end
    n_vec++; if (bus.src1_phys !== AW'(0)) begin n_err++; $display("FAIL t1_src1 got %0d want 0", bus.src1_phys); end
    tick();
    idle();
    bus.rename_instr = mk(0, 5, 0);
    #2;
    n_vec++; if (bus.free_count !== 8'd95) begin n_err++; $display("FAIL t1_count got %0d want 95", bus.free_count); end
    n_vec++; if (bus.src1_phys !== AW'(32)) begin n_err++; $display("FAIL t1_rat5 got %0d want 32", bus.src1_phys); end
    idle();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    bus.rename_valid = 1; bus.rename_has_dest = 1; bus.rename_instr = mk(1, 1, 1);
    #2;
    n_vec++; if (bus.src1_phys !== AW'(1) || bus.src2_phys !== AW'(1)) begin n_err++; $display("FAIL b2b_src_a got %0d/%0d want 1/1", bus.src1_phys, bus.src2_phys); end
    n_vec++; if (bus.rob_dest_reg !== AW'(32) || bus.rob_old_dest_reg !== AW'(1)) begin n_err++; $display("FAIL b2b_dest_a got %0d/%0d want 32/1", bus.rob_dest_reg, bus.rob_old_dest_reg); end
    tick();
    #2;
    n_vec++; if (bus.src1_phys !== AW'(32) || bus.src2_phys !== AW'(32)) begin n_err++; $display("FAIL b2b_src_b got %0d/%0d want 32/32", bus.src1_phys, bus.src2_phys); end
    n_vec++; if (bus.rob_dest_reg !== AW'(33) || bus.rob_old_dest_reg !== AW'(32)) begin n_err++; $display("FAIL b2b_dest_b got %0d/%0d want 33/32", bus.rob_dest_reg, bus.rob_old_dest_reg); end
    tick();
    idle();
  endtask

  task automatic test_rollback();
    bit exp_rb [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    bit exp_rdy[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int c = 0; c < 4; c++) begin
      idle();
      bus.rename_valid = 1; bus.rename_has_dest = 1; bus.rename_instr = mk(9, 1, 0);
      if (c < 2) begin
        bus.rollback_valid = 1; bus.rollback_instr = mk(1, 1, 1);
        bus.rollback_dest_reg     = (c == 0) ? AW'(33) : AW'(32);
        bus.rollback_old_dest_reg = (c == 0) ? AW'(32) : AW'(1);
      end
      #2;
      n_vec++; if (bus.rolling_back !== exp_rb[c]) begin n_err++; $display("FAIL rb_state c%0d got %0b want %0b", c, bus.rolling_back, exp_rb[c]); end
      n_vec++; if (bus.rename_ready !== exp_rdy[c]) begin n_err++; $display("FAIL rb_ready c%0d got %0b want %0b", c, bus.rename_ready, exp_rdy[c]); end
      if (c < 3) tick();
    end
    bus.rename_valid = 0;
    #1;
    n_vec++; if (bus.src1_phys !== AW'(1)) begin n_err++; $display("FAIL rb_rat1 got %0d want 1", bus.src1_phys); end
    n_vec++; if (bus.free_count !== 8'd96) begin n_err++; $display("FAIL rb_count got %0d want 96", bus.free_count); end
    for (int i = 0; i < 96; i++) begin
      idle();
      bus.rename_valid = 1; bus.rename_has_dest = 1; bus.rename_instr = mk(3, 0, 0);
      #2;
      n_vec++;
      if (bus.rob_dest_reg !== AW'(i < 94 ? 34 + i : (i == 94 ? 33 : 32))) begin
        n_err++; $display("FAIL rb_order i%0d got %0d want %0d", i, bus.rob_dest_reg, i < 94 ? 34 + i : (i == 94 ? 33 : 32));
      end
      tick();
    end
    idle();
  endtask

  task automatic test_exhaust();
    apply_reset();
    for (int i = 0; i < 96; i++) begin
      bus.rename_valid = 1; bus.rename_has_dest = 1; bus.rename_instr = mk(3, $urandom_range(0, 31), $urandom_range(0, 31));
      #2;
      n_vec++; if (bus.rob_write_en !== 1'b1 || bus.rob_dest_reg !== AW'(32 + i)) begin n_err++; $display("FAIL ex_fill i%0d got wen=%0b dest=%0d want 1/%0d", i, bus.rob_write_en, bus.rob_dest_reg, 32 + i); end
      tick();
    end
    bus.rename_instr = mk(3, 0, 0);
    #2;
    n_vec++; if (bus.free_count !== 8'd0) begin n_err++; $display("FAIL ex_count got %0d want 0", bus.free_count); end
    n_vec++; if (bus.rename_ready !== 1'b0 || bus.rob_write_en !== 1'b0) begin n_err++; $display("FAIL ex_stall got rdy=%0b wen=%0b want 0/0", bus.rename_ready, bus.rob_write_en); end
    tick();
    bus.rename_instr = mk(0, 0, 0);
    #2;
    n_vec++; if (bus.rob_write_en !== 1'b1 || bus.rob_dest_reg !== AW'(0) || bus.rob_old_dest_reg !== AW'(0)) begin n_err++; $display("FAIL ex_x0 got wen=%0b dest=%0d old=%0d want 1/0/0", bus.rob_write_en, bus.rob_dest_reg, bus.rob_old_dest_reg); end
    tick();
    bus.rename_has_dest = 0; bus.rename_instr = mk(4, 0, 0);
    #2;
    n_vec++; if (bus.rob_write_en !== 1'b1 || bus.rob_dest_reg !== AW'(0)) begin n_err++; $display("FAIL ex_nodest got wen=%0b dest=%0d want 1/0", bus.rob_write_en, bus.rob_dest_reg); end
    tick();
    idle();
    bus.retire_valid = 1; bus.retire_old_dest_reg = AW'(3);
    tick();
    idle();
    bus.rename_valid = 1; bus.rename_has_dest = 1; bus.rename_instr = mk(3, 0, 0);
    #2;
    n_vec++; if (bus.free_count !== 8'd1) begin n_err++; $display("FAIL ex_retire_count got %0d want 1", bus.free_count); end
    n_vec++; if (bus.rename_ready !== 1'b1 || bus.rob_dest_reg !== AW'(3)) begin n_err++; $display("FAIL ex_retire_alloc got rdy=%0b dest=%0d want 1/3", bus.rename_ready, bus.rob_dest_reg); end
    tick();
    idle();
  endtask

  task automatic test_rename_retire();
    apply_reset();
    bus.rename_valid = 1; bus.rename_has_dest = 1; bus.rename_instr = mk(7, 0, 0);
    bus.retire_valid = 1; bus.retire_old_dest_reg = AW'(40);
    #2;
    n_vec++; if (bus.rob_dest_reg !== AW'(32)) begin n_err++; $display("FAIL rr_dest got %0d want 32", bus.rob_dest_reg); end
    tick();
    idle();
    #2;
    n_vec++; if (bus.free_count !== 8'd96) begin n_err++; $display("FAIL rr_count got %0d want 96", bus.free_count); end
    for (int i = 0; i < 96; i++) begin
      bus.rename_valid = 1; bus.rename_has_dest = 1; bus.rename_instr = mk(8, 0, 0);
      #2;
      n_vec++; if (bus.rob_dest_reg !== AW'(i < 95 ? 33 + i : 40)) begin n_err++; $display("FAIL rr_order i%0d got %0d want %0d", i, bus.rob_dest_reg, i < 95 ? 33 + i : 40); end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid_rollback();
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      bus.rename_valid = 1; bus.rename_has_dest = 1; bus.rename_instr = mk(5, 0, 0);
      tick();
    end
    idle();
    bus.rollback_valid = 1; bus.rollback_instr = mk(5, 0, 0);
    bus.rollback_dest_reg = AW'(38); bus.rollback_old_dest_reg = AW'(37);
    tick();
    #2;
    n_vec++; if (bus.free_count !== 8'd90 || bus.rolling_back !== 1'b1) begin n_err++; $display("FAIL mr_pre got count=%0d rb=%0b want 90/1", bus.free_count, bus.rolling_back); end
    rst_n = 0;
    #1;
    n_vec++; if (bus.rolling_back !== 1'b0) begin n_err++; $display("FAIL mr_rb_in_reset got %0b want 0", bus.rolling_back); end
    @(posedge clk);
    #1;
    rst_n = 1;
    idle();
    model_reset();
    #2;
    n_vec++; if (bus.free_count !== 8'd96 || bus.rolling_back !== 1'b0) begin n_err++; $display("FAIL mr_post got count=%0d rb=%0b want 96/0", bus.free_count, bus.rolling_back); end
    for (int i = 0; i < 32; i++) begin
      bus.rename_instr = mk(0, i, 31 - i);
      #1;
      n_vec++; if (bus.src1_phys !== AW'(i) || bus.src2_phys !== AW'(31 - i)) begin n_err++; $display("FAIL mr_rat i%0d got %0d/%0d want %0d/%0d", i, bus.src1_phys, bus.src2_phys, i, 31 - i); end
    end
    idle();
  endtask

  task automatic test_random();
    int          rb_left;
    bit          rdy, acc, need;
    int          edest, eold, rd, rs1, rs2;
    logic [31:0] ins;
    rob_e_t      e;
    rb_left = 0;
    apply_reset();
    rob_q.delete();
    for (int c = 0; c < 700; c++) begin
      idle();
      if (rb_left > 0 && rob_q.size() > 0) begin
        e = rob_q.pop_back();
        bus.rollback_valid = 1; bus.rollback_instr = e.instr;
        bus.rollback_dest_reg = AW'(e.dest); bus.rollback_old_dest_reg = AW'(e.old);
        rb_left--;
      end else begin
        rb_left = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 5)) : 0;
      end
      if (rob_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        e = rob_q.pop_front();
        bus.retire_valid = 1; bus.retire_old_dest_reg = AW'(e.old);
      end
      ins = $urandom();
      bus.rename_valid    = $urandom_range(0, 1) != 0;
      bus.rename_instr    = ins;
      bus.rename_has_dest = $urandom_range(0, 3) != 0;
      bus.rob_full        = (rob_q.size() >= 48) || ($urandom_range(0, 7) == 0);
      #2;
      rd = int'(ins[11:7]); rs1 = int'(ins[19:15]); rs2 = int'(ins[24:20]);
      need  = m_need();
      rdy   = m_ready();
      acc   = bus.rename_valid && rdy;
      edest = (need && m_fl.size() > 0) ? m_fl[0] : 0;
      eold  = need ? m_rat[rd] : 0;
      n_vec++; if (bus.rename_ready !== rdy || bus.rob_write_en !== acc) begin n_err++; $display("FAIL rnd_hs c%0d got rdy=%0b wen=%0b want %0b/%0b", c, bus.rename_ready, bus.rob_write_en, rdy, acc); end
      n_vec++; if (bus.free_count !== 8'(m_fl.size()) || bus.rolling_back !== m_rb) begin n_err++; $display("FAIL rnd_state c%0d got count=%0d rb=%0b want %0d/%0b", c, bus.free_count, bus.rolling_back, m_fl.size(), m_rb); end
      if (acc) begin
        n_vec++; if (bus.rob_dest_reg !== AW'(edest) || bus.rob_old_dest_reg !== AW'(eold)) begin n_err++; $display("FAIL rnd_dest c%0d got %0d/%0d want %0d/%0d", c, bus.rob_dest_reg, bus.rob_old_dest_reg, edest, eold); end
        n_vec++; if (bus.src1_phys !== AW'(m_rat[rs1]) || bus.src2_phys !== AW'(m_rat[rs2])) begin n_err++; $display("FAIL rnd_src c%0d got %0d/%0d want %0d/%0d", c, bus.src1_phys, bus.src2_phys, m_rat[rs1], m_rat[rs2]); end
        n_vec++; if (bus.rob_instr !== ins) begin n_err++; $display("FAIL rnd_instr c%0d got %h want %h", c, bus.rob_instr, ins); end
        rob_q.push_back('{ins, edest, eold});
      end
      tick();
    end
    idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    idle();
    test_reset();
    test_first_rename();
    test_back_to_back();
    test_rollback();
    test_exhaust();
    test_rename_retire();
    test_reset_mid_rollback();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/register_renamer.md
Name: register_renamer

Overview:
- Front-end rename stage that writes into the reorder buffer.
- Holds the architectural-to-physical register alias table (RAT) and the physical-register free list.
- For each accepted instruction: allocates a new destination physical register, reports the previous mapping and source mappings, and issues the ROB write.
- Consumes the ROB's retire stream (frees old mappings) and rollback stream (restores the RAT and returns allocated registers).

Parameters:
REG_FILE_ADDR_WIDTH, 7, physical register index width (2^7 = 128 physical registers)
ARCH_REG_COUNT, 32, architectural registers; x0 is hard-mapped to physical 0

Ports:
clock  input  1  single clock; all state changes on the rising edge
reset  input  1  synchronous, active-low; sampled on the rising edge of clock
rename_valid  input  1  decoder presents an instruction
rename_ready  output  1  renamer can accept this cycle
rename_instr  input  32  instruction; rd=[11:7], rs1=[19:15], rs2=[24:20]
rename_has_dest  input  1  instruction writes rd
src1_phys  output  REG_FILE_ADDR_WIDTH  RAT[rs1], from the pre-update RAT
src2_phys  output  REG_FILE_ADDR_WIDTH  RAT[rs2], from the pre-update RAT
rob_full  input  1  ROB full flag
rob_write_en  output  1  ROB write strobe (equals accept)
rob_instr  output  32  rename_instr forwarded to the ROB
rob_dest_reg  output  REG_FILE_ADDR_WIDTH  newly allocated physical register, or 0
rob_old_dest_reg  output  REG_FILE_ADDR_WIDTH  previous RAT[rd], or 0
retire_valid  input  1  ROB retiring its head entry
retire_old_dest_reg  input  REG_FILE_ADDR_WIDTH  old mapping of the retiring entry
rollback_valid  input  1  ROB popping its youngest entry during rollback
rollback_instr  input  32  instruction of the popped entry
rollback_dest_reg  input  REG_FILE_ADDR_WIDTH  dest_reg of the popped entry
rollback_old_dest_reg  input  REG_FILE_ADDR_WIDTH  old_dest_reg of the popped entry
free_count  output  REG_FILE_ADDR_WIDTH+1  number of free physical registers
rolling_back  output  1  FSM is in ROLLBACK

Behaviour:
- Reset (reset==0 at an edge):
  - RAT[i]=i for i in 0..31.
  - Free-list FIFO holds 32..127 in ascending order, with head at 32.
  - free_count=96; FSM=NORMAL.
  - rename_ready, rob_write_en and rolling_back are 0 during reset.
  - Reset mid-rollback or mid-rename discards all state.
- needs_alloc = rename_has_dest && rd!=0.
- rename_ready = FSM==NORMAL && !rollback_valid && !rob_full && (free_count!=0 || !needs_alloc).
- accept = rename_valid && rename_ready; rob_write_en=accept (combinational, zero latency).
- Output fields on accept with needs_alloc:
  - rob_dest_reg = free-list head.
  - rob_old_dest_reg = RAT[rd].
  - At the edge: pop the free list and set RAT[rd]=rob_dest_reg.
- Output fields on accept without needs_alloc:
  - rob_dest_reg=0, rob_old_dest_reg=0.
  - No pop, no RAT change.
- Source lookups always read the RAT before the same-cycle update, so "add x1,x1,x1" sees the old x1 mapping.
- Retire:
  - retire_valid && retire_old_dest_reg!=0 pushes retire_old_dest_reg to the free-list tail.
  - Physical 0 is never pushed.
- FSM has two states: NORMAL and ROLLBACK.
  - NORMAL->ROLLBACK when rollback_valid=1; that cycle's pop is also processed.
  - ROLLBACK stays while rollback_valid=1.
  - ROLLBACK->NORMAL on the first cycle with rollback_valid=0; renaming resumes the cycle after.
- Rollback pop:
  - If rollback_dest_reg!=0: RAT[rollback_instr[11:7]] = rollback_old_dest_reg, and push rollback_dest_reg.
  - Entries arrive youngest-first, so the final RAT equals the mapping at the oldest surviving entry.
- Simultaneous events:
  - Rename pop + retire push in the same cycle: both take effect; free_count is unchanged.
  - Retire and rollback in the same cycle: both pushes must land. The free list has two write ports; tail advances by 2, rollback entry written first.
  - Rename cannot coincide with rollback (rename_ready=0).
- Free list:
  - Circular buffer of 128 entries; head and tail pointers wrap modulo 128.
  - free_count = pushes - pops since reset, range 0..128.
  - A push that would make free_count exceed 128 is a protocol error; the verification assertion fires, and behaviour is undefined.
- RAT[0] is never written; src*_phys for x0 is always 0.

Test Plan:
1. Reset, then rename "addi x5,x0,1" (has_dest=1) -> rob_write_en=1, rob_dest_reg=32, rob_old_dest_reg=5, src1_phys=0; next cycle free_count=95, RAT[5]=32.
2. Rename "add x1,x1,x1" twice back-to-back -> first: src1/src2=1, dest=32, old=1; second: src1/src2=32, dest=33, old=32.
3. Rename 96 instructions with rd=x3 and no retire -> free_count=0, rename_ready=0; an instruction with rd=x0 or has_dest=0 is still accepted with dest=0; retire old=3 -> next cycle free_count=1, ready=1.
4. After test 2, rollback the 2 entries (youngest-first) -> rolling_back=1 for 2 cycles, rename_ready=0 for 3 cycles; afterwards RAT[1]=1, free_count=96, and the free-list order after 34..127 is 33, 32.
5. Same-cycle rename (alloc) + retire (old=40) -> free_count unchanged; 40 appears at the free-list tail.
6. Assert reset during rollback with free_count=90 -> next cycle free_count=96, rolling_back=0, RAT identity.
